// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for a shared multi-unit ALU.
module alu_arbiter #(
    parameter int OP_DATA_WIDTH   = 16,
    parameter int ARITH_OUT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [3:0]                 req0_fun,
    input  logic [OP_DATA_WIDTH-1:0]   req0_a,
    input  logic [OP_DATA_WIDTH-1:0]   req0_b,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [3:0]                 req1_fun,
    input  logic [OP_DATA_WIDTH-1:0]   req1_a,
    input  logic [OP_DATA_WIDTH-1:0]   req1_b,
    output logic [OP_DATA_WIDTH-1:0]   alu_a,
    output logic [OP_DATA_WIDTH-1:0]   alu_b,
    output logic [3:0]                 alu_fun,
    input  logic [ARITH_OUT_WIDTH-1:0] Arith_OUT,
    input  logic [15:0]                Logic_Out,
    input  logic [15:0]                CMP_Out,
    input  logic [15:0]                Shift_Out,
    input  logic                       Arith_Flag,
    input  logic                       Logic_Flag,
    input  logic                       CMP_Flag,
    input  logic                       Shift_Flag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [ARITH_OUT_WIDTH-1:0] rsp_data,
    output logic                       rsp_err,
    output logic                       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam int EXT = ARITH_OUT_WIDTH - 16;
    logic [1:0]                 state_q, state_d;
    logic                       pri_q, pri_d;
    logic [OP_DATA_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]                 alu_fun_q, alu_fun_d;
    logic                       rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [ARITH_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d, sel_data;
    logic                       g0, g1, grant, div0, sel_flag;
    logic [3:0]                 gfun;
    logic [OP_DATA_WIDTH-1:0]   ga, gb;
    always_comb begin
        g0       = req0_valid && (!req1_valid || !pri_q);
        g1       = req1_valid && !g0;
        grant    = state_q == IDLE && (g0 || g1);
        gfun     = g1 ? req1_fun : req0_fun;
        ga       = g1 ? req1_a : req0_a;
        gb       = g1 ? req1_b : req0_b;
        div0     = gfun == 4'b0011 && gb == '0;
        sel_flag = alu_fun_q[3:2] == 2'b00 ? Arith_Flag :
                   alu_fun_q[3:2] == 2'b01 ? Logic_Flag :
                   alu_fun_q[3:2] == 2'b10 ? CMP_Flag : Shift_Flag;
        sel_data = alu_fun_q[3:2] == 2'b00 ? Arith_OUT :
                   alu_fun_q[3:2] == 2'b01 ? {{EXT{1'b0}}, Logic_Out} :
                   alu_fun_q[3:2] == 2'b10 ? {{EXT{1'b0}}, CMP_Out} : {{EXT{1'b0}}, Shift_Out};
        state_d    = grant ? (div0 ? RESP : ISSUE) :
                     state_q == ISSUE ? WAIT :
                     state_q == WAIT ? RESP :
                     (state_q == RESP && rsp_ready) ? IDLE : state_q;
        pri_d      = grant ? g0 : pri_q;
        alu_a_d    = grant && !div0 ? ga : alu_a_q;
        alu_b_d    = grant && !div0 ? gb : alu_b_q;
        alu_fun_d  = grant && !div0 ? gfun : alu_fun_q;
        rsp_id_d   = grant ? g1 : rsp_id_q;
        rsp_data_d = grant ? '0 : state_q == WAIT ? (sel_flag ? sel_data : '0) : rsp_data_q;
        rsp_err_d  = grant ? div0 : state_q == WAIT ? !sel_flag : rsp_err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pri_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= 4'b0000;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
    assign req0_ready = grant && g0 && !rst;
    assign req1_ready = grant && g1 && !rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_fun    = alu_fun_q;
    assign rsp_valid  = state_q == RESP;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = state_q != IDLE;
endmodule
